// File: rtl/local_controller_prefetch_mc.sv
// Ring-node sample buffer with NUM_CH prefetch channels.
// Channels replay buffer windows as tagged packets via a round-robin arbiter.
module local_controller_prefetch_mc #(
    parameter int DATAWIDTH  = 16,
    parameter int ADDR_VEC_W = 4,
    parameter int SAMPLE_AW  = 8,
    parameter int NUM_CH     = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PACKET_W  = 2 + 2*DATAWIDTH + ADDR_VEC_W
) (
    input  logic                   CLK,
    input  logic                   reset_n,
    input  logic [2*DATAWIDTH-1:0] D,
    input  logic                   write_flag,
    input  logic                   input_write_boundary,
    output logic                   write_boundary_next,
    output logic [SAMPLE_AW-1:0]   wr_ptr,
    input  logic                   pf_valid,
    input  logic [CH_W-1:0]        pf_ch,
    input  logic [SAMPLE_AW-1:0]   pf_start,
    input  logic [SAMPLE_AW-1:0]   pf_stop,
    input  logic [ADDR_VEC_W-1:0]  pf_dest,
    output logic [NUM_CH-1:0]      pf_busy,
    input  logic                   scenario_update,
    output logic [PACKET_W-1:0]    packet_out,
    output logic                   packet_valid,
    input  logic                   packet_ready
);

    localparam int DEPTH = 2**SAMPLE_AW;
    localparam logic [SAMPLE_AW-1:0] LAST = SAMPLE_AW'(DEPTH-1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH-1);

    typedef enum logic {
        WR_IDLE,
        WR_ACTIVE
    } wr_state_t;

    wr_state_t wr_state;

    logic [2*DATAWIDTH-1:0] mem [DEPTH];
    logic                   wr_en;

    logic [SAMPLE_AW-1:0]  ch_rd   [NUM_CH];
    logic [SAMPLE_AW-1:0]  ch_stop [NUM_CH];
    logic [ADDR_VEC_W-1:0] ch_dest [NUM_CH];
    logic [NUM_CH-1:0]     ch_head;
    logic [CH_W-1:0]       rr_ptr;

    logic [CH_W-1:0]        gnt;
    logic                   gnt_vld;
    logic [SAMPLE_AW-1:0]   rd_g;
    logic                   tail_g;
    logic [2*DATAWIDTH-1:0] rd_data;
    logic                   load_en;
    logic                   pf_ok;

    // A flush cycle never commits a sample.
    assign wr_en = (wr_state == WR_ACTIVE) && !scenario_update;

    // Write token FSM: stream one full buffer lap, then pass the token on.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            wr_state            <= WR_IDLE;
            wr_ptr              <= '0;
            write_boundary_next <= 1'b0;
        end else if (scenario_update) begin
            wr_state            <= WR_IDLE;
            wr_ptr              <= '0;
            write_boundary_next <= 1'b0;
        end else begin
            write_boundary_next <= 1'b0;
            unique case (wr_state)
                WR_IDLE: begin
                    if (write_flag || input_write_boundary)
                        wr_state <= WR_ACTIVE;
                end
                WR_ACTIVE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (wr_ptr == LAST) begin
                        wr_state            <= WR_IDLE;
                        write_boundary_next <= 1'b1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Sample buffer write port; left unreset so it can map onto RAM.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[wr_ptr] <= D;
    end

    // Round-robin pick: first busy channel at or after rr_ptr.
    always_comb begin
        int sum;
        logic [CH_W-1:0] cand;
        sum     = 0;
        cand    = '0;
        gnt     = '0;
        gnt_vld = 1'b0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            sum = int'(rr_ptr) + i;
            if (sum >= NUM_CH)
                sum = sum - NUM_CH;
            cand = CH_W'(sum);
            if (pf_busy[cand]) begin
                gnt     = cand;
                gnt_vld = 1'b1;
            end
        end
    end

    assign rd_g    = ch_rd[gnt];
    assign tail_g  = (rd_g == ch_stop[gnt]);
    assign rd_data = mem[rd_g];
    assign load_en = !packet_valid || packet_ready;
    assign pf_ok   = pf_valid && !pf_busy[pf_ch] && (int'(pf_ch) < NUM_CH);

    // Channel loading, per-channel read progress and the output register.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            pf_busy      <= '0;
            ch_head      <= '0;
            rr_ptr       <= '0;
            packet_valid <= 1'b0;
            packet_out   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ch_rd[c]   <= '0;
                ch_stop[c] <= '0;
                ch_dest[c] <= '0;
            end
        end else if (scenario_update) begin
            pf_busy      <= '0;
            rr_ptr       <= '0;
            packet_valid <= 1'b0;
        end else begin
            if (pf_ok) begin
                pf_busy[pf_ch] <= 1'b1;
                ch_rd[pf_ch]   <= pf_start;
                ch_stop[pf_ch] <= pf_stop;
                ch_dest[pf_ch] <= pf_dest;
                ch_head[pf_ch] <= 1'b1;
            end
            if (load_en) begin
                packet_valid <= gnt_vld;
                if (gnt_vld) begin
                    packet_out   <= {ch_head[gnt], tail_g, ch_dest[gnt], rd_data};
                    ch_rd[gnt]   <= rd_g + 1'b1;
                    ch_head[gnt] <= 1'b0;
                    if (tail_g)
                        pf_busy[gnt] <= 1'b0;
                    rr_ptr <= (gnt == CH_LAST) ? '0 : gnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_local_controller_prefetch_mc.sv
// Bench for local_controller_prefetch_mc.
// Random samples and windows checked against a window/round-robin model.
module tb_local_controller_prefetch_mc;

    localparam int DW    = 16;
    localparam int AVW   = 4;
    localparam int AW    = 8;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int PW    = 2 + 2*DW + AVW;
    localparam int DEPTH = 256;

    logic            CLK = 1'b0;
    logic            reset_n = 1'b0;
    logic [2*DW-1:0] D = '0;
    logic            write_flag = 1'b0;
    logic            input_write_boundary = 1'b0;
    logic            write_boundary_next;
    logic [AW-1:0]   wr_ptr;
    logic            pf_valid = 1'b0;
    logic [CHW-1:0]  pf_ch = '0;
    logic [AW-1:0]   pf_start = '0;
    logic [AW-1:0]   pf_stop = '0;
    logic [AVW-1:0]  pf_dest = '0;
    logic [NCH-1:0]  pf_busy;
    logic            scenario_update = 1'b0;
    logic [PW-1:0]   packet_out;
    logic            packet_valid;
    logic            packet_ready = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [2*DW-1:0] mem_m [DEPTH];
    logic [PW-1:0]   exp_q [$];

    local_controller_prefetch_mc dut (
        .CLK                  (CLK),
        .reset_n              (reset_n),
        .D                    (D),
        .write_flag           (write_flag),
        .input_write_boundary (input_write_boundary),
        .write_boundary_next  (write_boundary_next),
        .wr_ptr               (wr_ptr),
        .pf_valid             (pf_valid),
        .pf_ch                (pf_ch),
        .pf_start             (pf_start),
        .pf_stop              (pf_stop),
        .pf_dest              (pf_dest),
        .pf_busy              (pf_busy),
        .scenario_update      (scenario_update),
        .packet_out           (packet_out),
        .packet_valid         (packet_valid),
        .packet_ready         (packet_ready)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [PW-1:0] pkt(input bit h, input bit t,
                                          input logic [AVW-1:0] d,
                                          input int a);
        return {h, t, d, mem_m[a % DEPTH]};
    endfunction

    // Window = inclusive [s,e] modulo DEPTH; head on first, tail on last.
    task automatic push_window(input int s, input int e, input logic [AVW-1:0] d);
        int len;
        len = ((e - s) % DEPTH + DEPTH) % DEPTH + 1;
        for (int i = 0; i < len; i++)
            exp_q.push_back(pkt(i == 0, i == len-1, d, s + i));
    endtask

    task automatic drive_pf(input int ch, input int s, input int e, input logic [AVW-1:0] d);
        pf_valid = 1'b1;
        pf_ch    = CHW'(ch);
        pf_start = AW'(s);
        pf_stop  = AW'(e);
        pf_dest  = d;
    endtask

    // Accept n packets, compare in order, check hold during stalls.
    task automatic collect(input int n, input int pct, input int stall_at, input string name);
        int got;
        int cyc;
        logic prev_stall;
        logic [PW-1:0] prev_out;
        logic [PW-1:0] e;
        got = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_out = '0;
        while (got < n && cyc < 2000) begin
            if (cyc >= stall_at && cyc < stall_at + 5)
                packet_ready = 1'b0;
            else
                packet_ready = ($urandom_range(99) < pct);
            if (prev_stall) begin
                tests++;
                if (packet_valid !== 1'b1 || packet_out !== prev_out) begin
                    fails++;
                    $display("FAIL %s hold: got v=%b %h want v=1 %h",
                             name, packet_valid, packet_out, prev_out);
                end
            end
            if (packet_valid && packet_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL %s extra: got %h want none", name, packet_out);
                end else begin
                    e = exp_q.pop_front();
                    if (packet_out !== e) begin
                        fails++;
                        $display("FAIL %s pkt%0d: got %h want %h", name, got, packet_out, e);
                    end
                end
                got++;
            end
            prev_stall = packet_valid && !packet_ready;
            prev_out   = packet_out;
            tick();
            pf_valid = 1'b0;
            cyc++;
        end
        packet_ready = 1'b1;
        tests++;
        if (got != n || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s count: got %0d left %0d want %0d left 0",
                     name, got, exp_q.size(), n);
        end
        tests++;
        if (packet_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s idle: got valid=%b want 0", name, packet_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests++;
        if ({packet_valid, packet_out, write_boundary_next, wr_ptr, pf_busy} !== '0) begin
            fails++;
            $display("FAIL reset: got v=%b p=%h wb=%b wp=%h b=%b want all 0",
                     packet_valid, packet_out, write_boundary_next, wr_ptr, pf_busy);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_token(input bit ring);
        int pulses;
        pulses = 0;
        if (ring) input_write_boundary = 1'b1;
        else      write_flag = 1'b1;
        tick();
        write_flag = 1'b0;
        input_write_boundary = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            D = $urandom;
            mem_m[k] = D;
            if (k == 100) input_write_boundary = 1'b1;
            tick();
            input_write_boundary = 1'b0;
            if (write_boundary_next) pulses++;
            tests++;
            if (wr_ptr !== AW'((k + 1) % DEPTH)) begin
                fails++;
                $display("FAIL token wr_ptr: got %0d want %0d", wr_ptr, (k + 1) % DEPTH);
            end
        end
        tests++;
        if (write_boundary_next !== 1'b1 || pulses != 1) begin
            fails++;
            $display("FAIL token boundary: got %b pulses %0d want 1 pulses 1",
                     write_boundary_next, pulses);
        end
        D = $urandom;
        tick();
        tick();
        tests++;
        if (write_boundary_next !== 1'b0 || wr_ptr !== '0) begin
            fails++;
            $display("FAIL token idle: got wb=%b wp=%0d want 0 0", write_boundary_next, wr_ptr);
        end
    endtask

    task automatic test_window();
        packet_ready = 1'b1;
        drive_pf(0, 'h10, 'h13, 4'd6);
        tick();
        pf_valid = 1'b0;
        tests++;
        if (pf_busy[0] !== 1'b1 || packet_valid !== 1'b0) begin
            fails++;
            $display("FAIL window latency: got b=%b v=%b want 1 0", pf_busy[0], packet_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (packet_valid !== 1'b1 || packet_out !== pkt(i == 0, i == 3, 4'd6, 'h10 + i)
                || pf_busy[0] !== (i != 3)) begin
                fails++;
                $display("FAIL window pkt%0d: got v=%b %h b=%b want 1 %h %b", i,
                         packet_valid, packet_out, pf_busy[0],
                         pkt(i == 0, i == 3, 4'd6, 'h10 + i), i != 3);
            end
        end
        tick();
        tests++;
        if (packet_valid !== 1'b0) begin
            fails++;
            $display("FAIL window end: got v=%b want 0", packet_valid);
        end
    endtask

    task automatic test_wrap();
        logic [AVW-1:0] d;
        d = AVW'($urandom);
        push_window('hFE, 'h01, d);
        drive_pf(1, 'hFE, 'h01, d);
        collect(4, 100, -10, "wrap");
        d = AVW'($urandom);
        push_window('h55, 'h55, d);
        drive_pf(1, 'h55, 'h55, d);
        collect(1, 100, -10, "single");
    endtask

    task automatic test_random_windows();
        int ch, s, len, e;
        logic [AVW-1:0] d;
        for (int r = 0; r < 6; r++) begin
            ch  = $urandom_range(NCH - 1);
            s   = $urandom_range(DEPTH - 1);
            len = $urandom_range(20, 1);
            e   = (s + len - 1) % DEPTH;
            d   = AVW'($urandom);
            push_window(s, e, d);
            drive_pf(ch, s, e, d);
            collect(len, 70, -10, "random");
        end
    endtask

    task automatic test_arbitration(input int pct);
        logic [PW-1:0] qa [$];
        logic [PW-1:0] qb [$];
        exp_q.delete();
        push_window('h20, 'h22, 4'd1);
        qa = exp_q;
        exp_q.delete();
        push_window('h40, 'h42, 4'd2);
        qb = exp_q;
        exp_q.delete();
        exp_q.push_back(qa.pop_front());
        while (qa.size() != 0 || qb.size() != 0) begin
            if (qb.size() != 0) exp_q.push_back(qb.pop_front());
            if (qa.size() != 0) exp_q.push_back(qa.pop_front());
        end
        packet_ready = 1'b1;
        drive_pf(0, 'h20, 'h22, 4'd1);
        tick();
        drive_pf(2, 'h40, 'h42, 4'd2);
        collect(6, pct, -10, "arbitration");
    endtask

    task automatic test_backpressure();
        push_window('h30, 'h3F, 4'd9);
        drive_pf(3, 'h30, 'h3F, 4'd9);
        collect(16, 100, 4, "backpressure");
        push_window('hFA, 'h0A, 4'd3);
        drive_pf(2, 'hFA, 'h0A, 4'd3);
        collect(17, 40, 6, "backpressure_rand");
    endtask

    task automatic test_drop();
        packet_ready = 1'b0;
        push_window('h60, 'h6F, 4'd4);
        drive_pf(0, 'h60, 'h6F, 4'd4);
        tick();
        drive_pf(0, 'h80, 'h82, 4'd8);
        tick();
        pf_valid = 1'b0;
        tests++;
        if (pf_busy !== 4'b0001) begin
            fails++;
            $display("FAIL drop busy: got %b want 0001", pf_busy);
        end
        collect(16, 100, -10, "drop");
        push_window('h55, 'h55, 4'd2);
        drive_pf(1, 'h55, 'h55, 4'd2);
        tick();
        drive_pf(1, 'h70, 'h71, 4'd3);
        collect(1, 100, -10, "drop_finishing");
        tests++;
        if (pf_busy !== '0) begin
            fails++;
            $display("FAIL drop_finishing busy: got %b want 0000", pf_busy);
        end
    endtask

    task automatic test_flush();
        packet_ready = 1'b1;
        drive_pf(2, 'h00, 'h3F, 4'd5);
        tick();
        pf_valid = 1'b0;
        tick();
        tick();
        tick();
        scenario_update = 1'b1;
        drive_pf(3, 'h80, 'h81, 4'd7);
        tick();
        scenario_update = 1'b0;
        pf_valid = 1'b0;
        tests++;
        if (pf_busy !== '0 || packet_valid !== 1'b0 || write_boundary_next !== 1'b0) begin
            fails++;
            $display("FAIL flush: got b=%b v=%b wb=%b want 0 0 0",
                     pf_busy, packet_valid, write_boundary_next);
        end
        tick();
        tests++;
        if (pf_busy !== '0 || packet_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush after: got b=%b v=%b want 0 0", pf_busy, packet_valid);
        end
        write_flag = 1'b1;
        tick();
        write_flag = 1'b0;
        for (int k = 0; k < 10; k++) begin
            D = $urandom;
            mem_m[k] = D;
            tick();
        end
        tests++;
        if (wr_ptr !== AW'(10)) begin
            fails++;
            $display("FAIL flush write: got wp=%0d want 10", wr_ptr);
        end
        scenario_update = 1'b1;
        D = mem_m[10];
        tick();
        scenario_update = 1'b0;
        tick();
        tick();
        tests++;
        if (wr_ptr !== '0 || write_boundary_next !== 1'b0) begin
            fails++;
            $display("FAIL flush wr_ptr: got wp=%0d wb=%b want 0 0", wr_ptr, write_boundary_next);
        end
    endtask

    task automatic test_reset_mid();
        packet_ready = 1'b0;
        drive_pf(1, 'h00, 'h0F, 4'd3);
        tick();
        pf_valid = 1'b0;
        write_flag = 1'b1;
        tick();
        write_flag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            D = $urandom;
            mem_m[k] = D;
            tick();
        end
        tests++;
        if (packet_valid !== 1'b1 || wr_ptr !== AW'(3)) begin
            fails++;
            $display("FAIL pre-reset: got v=%b wp=%0d want 1 3", packet_valid, wr_ptr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({packet_valid, packet_out, write_boundary_next, wr_ptr, pf_busy} !== '0) begin
            fails++;
            $display("FAIL async reset: got v=%b p=%h wb=%b wp=%h b=%b want all 0",
                     packet_valid, packet_out, write_boundary_next, wr_ptr, pf_busy);
        end
        tick();
        reset_n = 1'b1;
        packet_ready = 1'b1;
        tick();
        tests++;
        if (packet_valid !== 1'b0 || pf_busy !== '0 || wr_ptr !== '0) begin
            fails++;
            $display("FAIL post-reset: got v=%b b=%b wp=%0d want 0 0 0",
                     packet_valid, pf_busy, wr_ptr);
        end
    endtask

    initial begin
        test_reset();
        test_token(1'b0);
        test_window();
        test_wrap();
        test_token(1'b1);
        test_random_windows();
        test_arbitration(100);
        test_arbitration(50);
        test_backpressure();
        test_drop();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
